stopwatch_ctrl: RTL and testbench

Control front-end for the 4-digit BCD count/display chain. Debounces five push-buttons and runs a start/stop/lap/clear state machine. Drives the count-enable, clear and 3-bit speed inputs of the prescaler and decade counters, and selects whether the scanned display shows the live or a frozen (lap) value. Sits between board buttons and the counter/display datapath, all on the 50 MHz system clock.

---
 rtl/stopwatch_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front-end: debounces five push-buttons, turns accepted
// presses into one-cycle events, and runs the IDLE/RUN/PAUSE/LAP machine that
// drives the prescaler/decade chain and chooses the live or lap display value.
// The buttons carry no handshake: an event is a single-cycle pulse that the
// FSM and speed logic consume in the cycle it is high, with no back-pressure.
module stopwatch_ctrl #(
  parameter int          DEB_CYCLES = 1000000,
  parameter logic [15:0] STOP_AT    = 16'h9999,
  parameter logic [2:0]  SPEED_INIT = 3'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_ss,
  input  logic        btn_clr,
  input  logic        btn_lap,
  input  logic        btn_fast,
  input  logic        btn_slow,
  input  logic [15:0] cnt_num,
  output logic        cnt_en,
  output logic        cnt_clr,
  output logic [2:0]  speed,
  output logic [15:0] disp_num,
  output logic [1:0]  state,
  output logic        done
);

  localparam int NB = 5;
  localparam int CW = $clog2(DEB_CYCLES + 1);
  // The accept happens on the edge where the counter would reach DEB_CYCLES.
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  // Button lanes: 0 ss, 1 clr, 2 lap, 3 fast, 4 slow.
  logic [NB-1:0] raw;
  logic [NB-1:0] sync1;
  logic [NB-1:0] sync2;
  logic [NB-1:0] stable;
  logic [NB-1:0] press;
  logic [CW-1:0] deb_cnt [NB];

  logic ev_ss, ev_clr, ev_lap, ev_fast, ev_slow;

  state_t      state_q, state_d;
  logic        clr_d;
  logic        done_d;
  logic [15:0] hold_q, hold_d;
  logic        at_stop;

  assign raw = {btn_slow, btn_fast, btn_lap, btn_clr, btn_ss};

  // Two-flop synchronizer for the asynchronous button inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Per-button stability counter; a press pulse fires when a rising level is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= '0;
      press  <= '0;
      for (int i = 0; i < NB; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] != stable[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            stable[i]  <= sync2[i];
            press[i]   <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign ev_ss   = press[0];
  assign ev_clr  = press[1];
  assign ev_lap  = press[2];
  assign ev_fast = press[3];
  assign ev_slow = press[4];
  assign at_stop = (cnt_num == STOP_AT);

  // Next-state logic: clr beats ss beats lap, auto-stop beats all events while counting.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    done_d  = done;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (ev_clr) begin
          clr_d  = 1'b1;
          done_d = 1'b0;
        end else if (ev_ss) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (at_stop) begin
          state_d = PAUSE;
          done_d  = 1'b1;
        end else if (ev_ss) begin
          state_d = PAUSE;
        end else if (ev_lap) begin
          state_d = LAP;
          hold_d  = cnt_num;
        end
      end
      LAP: begin
        if (at_stop) begin
          state_d = PAUSE;
          done_d  = 1'b1;
        end else if (ev_ss) begin
          state_d = PAUSE;
        end else if (ev_lap) begin
          state_d = RUN;
        end
      end
      PAUSE: begin
        if (ev_clr) begin
          state_d = IDLE;
          clr_d   = 1'b1;
          done_d  = 1'b0;
        end else if (ev_ss && !done) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; display follows the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_en   <= 1'b0;
      cnt_clr  <= 1'b0;
      done     <= 1'b0;
      hold_q   <= '0;
      disp_num <= '0;
    end else begin
      state_q  <= state_d;
      cnt_en   <= (state_d == RUN) || (state_d == LAP);
      cnt_clr  <= clr_d;
      done     <= done_d;
      hold_q   <= hold_d;
      disp_num <= (state_d == LAP) ? hold_d : cnt_num;
    end
  end

  // Speed code: saturating up/down, simultaneous presses cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      speed <= SPEED_INIT;
    end else if (ev_fast && !ev_slow && speed != 3'd7) begin
      speed <= speed + 3'd1;
    end else if (ev_slow && !ev_fast && speed != 3'd0) begin
      speed <= speed - 3'd1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a short debounce window. Expected
// output snapshots are queued before each stimulus step and popped for
// comparison once the DUT has had time to respond.
module tb_stopwatch_ctrl;

  localparam int DEB = 4;
  localparam int EV  = DEB + 3;  // raw edge to FSM reaction, in cycles

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_LAP   = 2'b11;

  // Button masks: bit0 ss, bit1 clr, bit2 lap, bit3 fast, bit4 slow.
  localparam logic [4:0] B_SS   = 5'b00001;
  localparam logic [4:0] B_CLR  = 5'b00010;
  localparam logic [4:0] B_LAP  = 5'b00100;
  localparam logic [4:0] B_FAST = 5'b01000;
  localparam logic [4:0] B_SLOW = 5'b10000;

  // clock / reset / stimulus signals
  logic        clk;
  logic        rst;
  logic [4:0]  btns;
  logic [15:0] cnt;
  logic        cnt_en;
  logic        cnt_clr;
  logic [2:0]  speed;
  logic [15:0] disp_num;
  logic [1:0]  state;
  logic        done;
  logic [23:0] obs;

  // scoreboard
  logic [23:0] exp_q[$];
  string       tag_q[$];
  int          errors = 0;
  int          checks = 0;

  stopwatch_ctrl #(
    .DEB_CYCLES(DEB),
    .STOP_AT(16'h9999),
    .SPEED_INIT(3'd0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_ss(btns[0]),
    .btn_clr(btns[1]),
    .btn_lap(btns[2]),
    .btn_fast(btns[3]),
    .btn_slow(btns[4]),
    .cnt_num(cnt),
    .cnt_en(cnt_en),
    .cnt_clr(cnt_clr),
    .speed(speed),
    .disp_num(disp_num),
    .state(state),
    .done(done)
  );

  assign obs = {state, cnt_en, cnt_clr, done, speed, disp_num};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] pk(logic [1:0] s, logic e, logic c, logic d,
                                     logic [2:0] sp, logic [15:0] dn);
    return {s, e, c, d, sp, dn};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_obs(input string tag, input logic [23:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check_pop();
    logic [23:0] e;
    string       t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%h expected=<none>", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed st=%b en=%b clr=%b done=%b spd=%0d disp=%h expected st=%b en=%b clr=%b done=%b spd=%0d disp=%h",
             t, obs[23:22], obs[21], obs[20], obs[19], obs[18:16], obs[15:0],
             e[23:22], e[21], e[20], e[19], e[18:16], e[15:0]);
    end
  endtask

  // Hold a button mask for EV cycles and compare the snapshot at the reaction edge.
  task automatic press_check(input logic [4:0] m, input string tag, input logic [23:0] v);
    expect_obs(tag, v);
    btns = m;
    step(EV);
    check_pop();
    btns = '0;
    step(EV + 1);
  endtask

  initial begin
    rst  = 1'b1;
    btns = '0;
    cnt  = 16'h0055;
    step(2);
    expect_obs("reset", pk(S_IDLE, 0, 0, 0, 3'd0, 16'h0000));
    check_pop();

    rst = 1'b0;
    cnt = 16'h0000;
    step(2);
    expect_obs("idle_after_reset", pk(S_IDLE, 0, 0, 0, 3'd0, 16'h0000));
    check_pop();

    // a 3-cycle glitch is shorter than the debounce window
    expect_obs("ss_glitch", pk(S_IDLE, 0, 0, 0, 3'd0, 16'h0000));
    btns = B_SS;
    step(3);
    btns = '0;
    step(10);
    check_pop();

    // held press: no reaction one cycle early, RUN exactly EV cycles after the edge
    expect_obs("ss_before_event", pk(S_IDLE, 0, 0, 0, 3'd0, 16'h0000));
    expect_obs("ss_event_run", pk(S_RUN, 1, 0, 0, 3'd0, 16'h0000));
    btns = B_SS;
    step(EV - 1);
    check_pop();
    step(1);
    check_pop();
    expect_obs("ss_single_event", pk(S_RUN, 1, 0, 0, 3'd0, 16'h0000));
    step(10 - EV);
    btns = '0;
    step(EV + 1);
    check_pop();

    // lap freezes the display while the count moves on
    cnt = 16'h0123;
    step(1);
    expect_obs("lap_enter", pk(S_LAP, 1, 0, 0, 3'd0, 16'h0123));
    btns = B_LAP;
    step(EV);
    check_pop();
    expect_obs("lap_frozen", pk(S_LAP, 1, 0, 0, 3'd0, 16'h0123));
    cnt = 16'h0130;
    step(2);
    check_pop();
    btns = '0;
    step(EV + 1);
    press_check(B_LAP, "lap_exit_live", pk(S_RUN, 1, 0, 0, 3'd0, 16'h0130));

    // clr is ignored while running, so ss wins
    press_check(B_CLR | B_SS, "run_clr_ss", pk(S_PAUSE, 0, 0, 0, 3'd0, 16'h0130));

    // in PAUSE clr outranks ss: back to IDLE with a one-cycle clear pulse
    expect_obs("pause_clr_ss", pk(S_IDLE, 0, 1, 0, 3'd0, 16'h0130));
    expect_obs("clr_pulse_end", pk(S_IDLE, 0, 0, 0, 3'd0, 16'h0130));
    btns = B_CLR | B_SS;
    step(EV);
    check_pop();
    step(1);
    check_pop();
    btns = '0;
    cnt  = 16'h0000;
    step(EV + 1);

    // auto-stop at 9999, then ss ignored, clr resets done
    press_check(B_SS, "run_again", pk(S_RUN, 1, 0, 0, 3'd0, 16'h0000));
    expect_obs("auto_stop", pk(S_PAUSE, 0, 0, 1, 3'd0, 16'h9999));
    cnt = 16'h9999;
    step(1);
    check_pop();
    expect_obs("auto_stop_hold", pk(S_PAUSE, 0, 0, 1, 3'd0, 16'h9999));
    step(3);
    check_pop();
    press_check(B_SS, "done_ss_ignored", pk(S_PAUSE, 0, 0, 1, 3'd0, 16'h9999));
    expect_obs("done_clr", pk(S_IDLE, 0, 1, 0, 3'd0, 16'h9999));
    expect_obs("done_clr_end", pk(S_IDLE, 0, 0, 0, 3'd0, 16'h0000));
    btns = B_CLR;
    step(EV);
    check_pop();
    cnt = 16'h0000;
    step(1);
    check_pop();
    btns = '0;
    step(EV + 1);

    // speed: climb to 7, saturate, fall to 0, saturate, cancel at 3
    for (int i = 1; i <= 7; i++)
      press_check(B_FAST, $sformatf("fast_%0d", i), pk(S_IDLE, 0, 0, 0, 3'(i), 16'h0000));
    press_check(B_FAST, "fast_sat", pk(S_IDLE, 0, 0, 0, 3'd7, 16'h0000));
    for (int i = 6; i >= 0; i--)
      press_check(B_SLOW, $sformatf("slow_%0d", i), pk(S_IDLE, 0, 0, 0, 3'(i), 16'h0000));
    press_check(B_SLOW, "slow_sat", pk(S_IDLE, 0, 0, 0, 3'd0, 16'h0000));
    for (int i = 1; i <= 3; i++)
      press_check(B_FAST, $sformatf("fast_up_%0d", i), pk(S_IDLE, 0, 0, 0, 3'(i), 16'h0000));
    press_check(B_FAST | B_SLOW, "fast_slow_cancel", pk(S_IDLE, 0, 0, 0, 3'd3, 16'h0000));

    // reset in the middle of a debounce while in LAP
    press_check(B_SS, "run_before_lap", pk(S_RUN, 1, 0, 0, 3'd3, 16'h0000));
    cnt = 16'h0200;
    step(1);
    press_check(B_LAP, "lap_before_rst", pk(S_LAP, 1, 0, 0, 3'd3, 16'h0200));
    btns = B_SS;
    step(3);
    expect_obs("async_reset", pk(S_IDLE, 0, 0, 0, 3'd0, 16'h0000));
    rst = 1'b1;
    #1;
    check_pop();
    step(2);
    rst = 1'b0;
    expect_obs("requal_before_event", pk(S_IDLE, 0, 0, 0, 3'd0, 16'h0200));
    expect_obs("requal_run", pk(S_RUN, 1, 0, 0, 3'd0, 16'h0200));
    step(EV - 1);
    check_pop();
    step(1);
    check_pop();
    btns = '0;
    step(EV + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
